// File: rtl/spdif_pkg.sv
// Shared S/PDIF constants: preamble toggle patterns, subframe geometry and slot indices.
// Used by the subframe builder, the serializer, the frame encoder and the BMC encoder bench.
package spdif_pkg;

    localparam int SUBFRAME_HALFCELLS = 64;
    localparam int SUBFRAME_SLOTS     = 32;
    localparam int AUDIO_W            = 24;
    localparam int PREAMBLE_CELLS     = 8;

    localparam int SLOT_AUDIO0 = 4;
    localparam int SLOT_V      = 28;
    localparam int SLOT_U      = 29;
    localparam int SLOT_C      = 30;
    localparam int SLOT_P      = 31;

    // Toggle patterns, first half-cell in the MSB; independent of line polarity.
    localparam logic [7:0] PREAMBLE_B = 8'b1001_1100;
    localparam logic [7:0] PREAMBLE_M = 8'b1001_0011;
    localparam logic [7:0] PREAMBLE_W = 8'b1001_0110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    // A data slot always toggles at its cell boundary, and mid-cell only for a 1.
    function automatic logic [1:0] slot_cells(input logic b);
        return {1'b1, b};
    endfunction

endpackage

// File: rtl/spdif_subframe_builder.sv
// Combinational mapping of one sample's fields onto the 64 half-cell toggle vector
// of a subframe, preamble first in bit 63, with even parity over slots 4-31.
module spdif_subframe_builder
    import spdif_pkg::*;
(
    input  logic [AUDIO_W-1:0]            audio_i,
    input  logic                          is_left_i,
    input  logic                          is_block_start_i,
    input  logic                          validity_i,
    input  logic                          user_i,
    input  logic                          channel_status_i,
    output logic [SUBFRAME_HALFCELLS-1:0] vec_o
);

    logic [SUBFRAME_SLOTS-1:SLOT_AUDIO0] slot_bits;
    logic [PREAMBLE_CELLS-1:0]           preamble;

    always_comb begin
        slot_bits                                 = '0;
        slot_bits[SLOT_AUDIO0 +: AUDIO_W]         = audio_i;
        slot_bits[SLOT_V]                         = validity_i;
        slot_bits[SLOT_U]                         = user_i;
        slot_bits[SLOT_C]                         = channel_status_i;
        slot_bits[SLOT_P]                         = ^slot_bits[SLOT_C:SLOT_AUDIO0];

        // Block start only distinguishes channel A; channel B is always W.
        if (!is_left_i) begin
            preamble = PREAMBLE_W;
        end else if (is_block_start_i) begin
            preamble = PREAMBLE_B;
        end else begin
            preamble = PREAMBLE_M;
        end

        vec_o = '0;
        vec_o[SUBFRAME_HALFCELLS-1 -: PREAMBLE_CELLS] = preamble;
        for (int s = SLOT_AUDIO0; s < SUBFRAME_SLOTS; s++) begin
            vec_o[SUBFRAME_HALFCELLS-1-2*s -: 2] = slot_cells(slot_bits[s]);
        end
    end

endmodule

// File: rtl/spdif_subframe_serializer.sv
// Latches a built subframe and streams it MSB-first as width-half-cell toggle chunks
// to the BMC encoder, with a combinational i_ready path for gapless back-to-back frames.
module spdif_subframe_serializer
    import spdif_pkg::*;
#(
    parameter int width = 4
) (
    input  logic               clk128,
    input  logic               reset,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [AUDIO_W-1:0] i_audio,
    input  logic               i_is_left,
    input  logic               i_is_block_start,
    input  logic               i_validity,
    input  logic               i_user,
    input  logic               i_channel_status,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [width-1:0]   o_data
);

    localparam int NCHUNK = SUBFRAME_HALFCELLS / width;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(NCHUNK - 1);

    generate
        if ((width < 2) || ((width % 2) != 0) || ((SUBFRAME_HALFCELLS % width) != 0)) begin : g_bad_width
            $error("spdif_subframe_serializer: width must be even and divide 64");
        end
    endgenerate

    ser_state_e                    state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [SUBFRAME_HALFCELLS-1:0] shift_q, shift_d;
    logic [SUBFRAME_HALFCELLS-1:0] frame_vec;
    logic                          last_chunk;
    logic                          accept;

    spdif_subframe_builder u_builder (
        .audio_i          (i_audio),
        .is_left_i        (i_is_left),
        .is_block_start_i (i_is_block_start),
        .validity_i       (i_validity),
        .user_i           (i_user),
        .channel_status_i (i_channel_status),
        .vec_o            (frame_vec)
    );

    always_comb begin
        last_chunk = (state_q == ST_SEND) && (cnt_q == '0);
        i_ready    = (state_q == ST_IDLE) || (last_chunk && o_ready);
        accept     = i_valid && i_ready;
        o_valid    = (state_q == ST_SEND);
        o_data     = o_valid ? shift_q[SUBFRAME_HALFCELLS-1 -: width] : '0;

        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;

        // A new accept on the last handshake reloads directly, so no idle cycle appears.
        if (accept) begin
            state_d = ST_SEND;
            cnt_d   = LAST_LOAD;
            shift_d = frame_vec;
        end else if (o_valid && o_ready) begin
            shift_d = shift_q << width;
            if (last_chunk) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_spdif_subframe_serializer.sv
// Directed bench for spdif_subframe_serializer (width=4) with hand-computed toggle vectors.
module tb_spdif_subframe_serializer;

    logic        clk128 = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        i_ready;
    logic [23:0] i_audio;
    logic        i_is_left;
    logic        i_is_block_start;
    logic        i_validity;
    logic        i_user;
    logic        i_channel_status;
    logic        o_valid;
    logic        o_ready;
    logic [3:0]  o_data;

    int vectors     = 0;
    int miscompares = 0;

    // Expected subframes, one nibble per chunk, first chunk in the top nibble.
    logic [63:0] exp_left_blk;   // B, audio 000001, VUC=000, P=1
    logic [63:0] exp_right_ff;   // W, audio FFFFFF, VUC=000, P=0
    logic [63:0] exp_left_vc;    // M, audio 0, V=1 U=0 C=1, P=0
    logic [63:0] exps [3];

    spdif_subframe_serializer #(.width(4)) dut (
        .clk128           (clk128),
        .reset            (reset),
        .i_valid          (i_valid),
        .i_ready          (i_ready),
        .i_audio          (i_audio),
        .i_is_left        (i_is_left),
        .i_is_block_start (i_is_block_start),
        .i_validity       (i_validity),
        .i_user           (i_user),
        .i_channel_status (i_channel_status),
        .o_valid          (o_valid),
        .o_ready          (o_ready),
        .o_data           (o_data)
    );

    always #5 clk128 = ~clk128;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk128);
        #1;
    endtask

    task automatic set_fields(input logic [23:0] a, input logic l, input logic b,
                              input logic v, input logic u, input logic c);
        i_audio          = a;
        i_is_left        = l;
        i_is_block_start = b;
        i_validity       = v;
        i_user           = u;
        i_channel_status = c;
    endtask

    // Present one sample from IDLE, then scribble the fields to show they were latched.
    task automatic load(input string tag, input logic [23:0] a, input logic l, input logic b,
                        input logic v, input logic u, input logic c);
        set_fields(a, l, b, v, u, c);
        i_valid = 1'b1;
        o_ready = 1'b0;
        #1;
        chk({tag, "_ready_idle"}, 64'(i_ready), 64'd1);
        chk({tag, "_valid_idle"}, 64'(o_valid), 64'd0);
        step();
        i_valid = 1'b0;
        set_fields(24'h5A5A5A, ~l, ~b, ~v, ~u, ~c);
    endtask

    // Drain one subframe; optional stall before chunk stall_at, optional reset at chunk abort_at.
    task automatic play(input string tag, input logic [63:0] expv, input int stall_at,
                        input int stall_len, input int abort_at);
        logic [3:0] want;
        for (int k = 0; k < 16; k++) begin
            want = expv[63-4*k -: 4];
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                chk({tag, "_rst_valid"}, 64'(o_valid), 64'd0);
                chk({tag, "_rst_data"},  64'(o_data),  64'd0);
                chk({tag, "_rst_ready"}, 64'(i_ready), 64'd1);
                step();
                reset = 1'b0;
                #1;
                chk({tag, "_post_rst_valid"}, 64'(o_valid), 64'd0);
                chk({tag, "_post_rst_data"},  64'(o_data),  64'd0);
                step();
                chk({tag, "_post_rst_idle"}, 64'(o_valid), 64'd0);
                return;
            end
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    o_ready = 1'b0;
                    #1;
                    chk({tag, "_stall_valid"}, 64'(o_valid), 64'd1);
                    chk({tag, "_stall_data"},  64'(o_data),  64'(want));
                    chk({tag, "_stall_ready"}, 64'(i_ready), 64'd0);
                    step();
                end
            end
            o_ready = 1'b1;
            #1;
            chk({tag, "_valid"}, 64'(o_valid), 64'd1);
            chk({tag, "_chunk"}, 64'(o_data),  64'(want));
            chk({tag, "_iready"}, 64'(i_ready), 64'(k == 15));
            step();
        end
        o_ready = 1'b0;
        #1;
        chk({tag, "_end_idle"}, 64'(o_valid), 64'd0);
        chk({tag, "_end_data"}, 64'(o_data),  64'd0);
    endtask

    initial begin
        exp_left_blk = 64'h9CEA_AAAA_AAAA_AAAB;
        exp_right_ff = 64'h96FF_FFFF_FFFF_FFAA;
        exp_left_vc  = 64'h93AA_AAAA_AAAA_AAEE;
        exps[0] = exp_left_blk;
        exps[1] = exp_right_ff;
        exps[2] = exp_left_vc;

        reset   = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b0;
        set_fields(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_data",  64'(o_data),  64'd0);
        chk("reset_ready", 64'(i_ready), 64'd1);
        reset = 1'b0;
        step();
        chk("released_ready", 64'(i_ready), 64'd1);
        chk("released_valid", 64'(o_valid), 64'd0);

        load("left_blk", 24'h000001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        play("left_blk", exp_left_blk, -1, 0, -1);

        load("right_ff", 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        play("right_ff", exp_right_ff, -1, 0, -1);

        load("left_vc", 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        play("left_vc", exp_left_vc, -1, 0, -1);

        load("bp", 24'h000001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        play("bp", exp_left_blk, 5, 7, -1);

        load("abort", 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play("abort", exp_right_ff, -1, 0, 9);
        load("after_abort", 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        play("after_abort", exp_left_vc, -1, 0, -1);

        // Gapless frames at the encoder's one-in-four o_ready cadence, i_valid held high.
        set_fields(24'h000001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b1;
        o_ready = 1'b0;
        #1;
        chk("b2b_first_ready", 64'(i_ready), 64'd1);
        step();
        set_fields(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 16; k++) begin
                for (int s = 0; s < 3; s++) begin
                    o_ready = 1'b0;
                    #1;
                    chk("b2b_wait_valid", 64'(o_valid), 64'd1);
                    chk("b2b_wait_data",  64'(o_data),  64'(exps[f][63-4*k -: 4]));
                    chk("b2b_wait_ready", 64'(i_ready), 64'd0);
                    step();
                end
                o_ready = 1'b1;
                #1;
                chk("b2b_valid",  64'(o_valid), 64'd1);
                chk("b2b_chunk",  64'(o_data),  64'(exps[f][63-4*k -: 4]));
                chk("b2b_iready", 64'(i_ready), 64'(k == 15));
                step();
                if (k == 15 && f == 0) set_fields(24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
                if (k == 15 && f == 1) i_valid = 1'b0;
            end
        end
        o_ready = 1'b0;
        #1;
        chk("b2b_final_idle", 64'(o_valid), 64'd0);
        chk("b2b_final_ready", 64'(i_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
